// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer.
// Holds the default geometry, the control-code constants, the writer state
// encoding, the cursor operation codes and the 18-bit cell-word layout.
package text_console_pkg;

  localparam int unsigned COLS_DEF = 120;
  localparam int unsigned ROWS_DEF = 61;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUT   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE      = 3'd0,
    CUR_ADVANCE   = 3'd1,
    CUR_NEWLINE   = 3'd2,
    CUR_RETURN    = 3'd3,
    CUR_BACKSPACE = 3'd4,
    CUR_HOME      = 3'd5
  } cursor_op_t;

  // Cell word: {BL[1:0], BG[3:0], FG[3:0], Char[7:0]}
  typedef struct packed {
    logic [1:0] bl;
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] ch;
  } cell_t;

  function automatic cell_t make_cell(input logic [1:0] bl,
                                      input logic [3:0] bg,
                                      input logic [3:0] fg,
                                      input logic [7:0] ch);
    cell_t c;
    c.bl = bl;
    c.bg = bg;
    c.fg = fg;
    c.ch = ch;
    return c;
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor counters for the text console writer.
// Ports:
//   clk50, rst_n : clock, asynchronous active-low reset
//   op           : cursor operation applied at the next rising edge
//   col, row     : current cursor position
//   addr         : linear cell address row*COLS+col
module text_cursor
  import text_console_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  cursor_op_t  op,
  output logic [6:0]  col,
  output logic [5:0]  row,
  output logic [12:0] addr
);

  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
  localparam logic [12:0] ROW_STEP = 13'(COLS);

  // row_base tracks row*COLS incrementally so no multiplier is needed
  logic [12:0] row_base;
  logic [5:0]  row_nxt;
  logic [12:0] base_nxt;

  always_comb begin
    row_nxt  = row + 6'd1;
    base_nxt = row_base + ROW_STEP;
    if (row == LAST_ROW) begin
      row_nxt  = '0;
      base_nxt = '0;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == LAST_COL) begin
            col      <= '0;
            row      <= row_nxt;
            row_base <= base_nxt;
          end else begin
            col <= col + 7'd1;
          end
        end
        CUR_NEWLINE: begin
          col      <= '0;
          row      <= row_nxt;
          row_base <= base_nxt;
        end
        CUR_RETURN: col <= '0;
        CUR_BACKSPACE: begin
          if (col != '0) col <= col - 7'd1;
        end
        CUR_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end
        default: ;
      endcase
    end
  end

  assign addr = row_base + {6'd0, col};

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into text-buffer cell writes.
// Ports:
//   clk50, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : byte handshake; in_data is the byte
//   attr_bl/attr_bg/attr_fg : attributes sampled with the byte
//   WAddr, WData, Write   : registered text-buffer write port
//   cursor_col/cursor_row : current cursor position
//   busy                  : high while a PUT or CLEAR is in progress
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [1:0]  attr_bl,
  input  logic [3:0]  attr_bg,
  input  logic [3:0]  attr_fg,
  output logic [12:0] WAddr,
  output logic [17:0] WData,
  output logic        Write,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);

  state_t      state;
  cursor_op_t  cur_op;
  logic [12:0] cur_addr;
  logic        accept;
  logic        clear_last;

  assign in_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign clear_last = (state == ST_CLEAR) && (WAddr == LAST_CELL);

  // The cursor advances on the accept edge; the cell address was already
  // captured into WAddr on that same edge, so the PUT cycle writes the old
  // position while the cursor outputs already show the new one.
  always_comb begin
    cur_op = CUR_NONE;
    if (accept) begin
      case (in_data)
        CH_CR:   cur_op = CUR_RETURN;
        CH_LF:   cur_op = CUR_NEWLINE;
        CH_BS:   cur_op = CUR_BACKSPACE;
        CH_FF:   cur_op = CUR_NONE;
        default: cur_op = CUR_ADVANCE;
      endcase
    end else if (clear_last) begin
      cur_op = CUR_HOME;
    end
  end

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk50 (clk50),
    .rst_n (rst_n),
    .op    (cur_op),
    .col   (cursor_col),
    .row   (cursor_row),
    .addr  (cur_addr)
  );

  // WAddr doubles as the CLEAR sweep counter; WData keeps the latched
  // clear attributes for the whole sweep.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      Write <= 1'b0;
      WAddr <= '0;
      WData <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          Write <= 1'b0;
          if (accept) begin
            case (in_data)
              CH_CR, CH_LF, CH_BS: ;
              CH_FF: begin
                state <= ST_CLEAR;
                Write <= 1'b1;
                WAddr <= '0;
                WData <= make_cell(attr_bl, attr_bg, attr_fg, CH_SPACE);
              end
              default: begin
                state <= ST_PUT;
                Write <= 1'b1;
                WAddr <= cur_addr;
                WData <= make_cell(attr_bl, attr_bg, attr_fg, in_data);
              end
            endcase
          end
        end
        ST_PUT: begin
          state <= ST_IDLE;
          Write <= 1'b0;
        end
        ST_CLEAR: begin
          if (clear_last) begin
            state <= ST_IDLE;
            Write <= 1'b0;
          end else begin
            WAddr <= WAddr + 13'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Write <= 1'b0;
        end
      endcase
    end
  end

endmodule
